// File: rtl/wdma0_if.sv
// AXI4 write-channel bundle (AW/W/B) between the wdma0 engine and the memory slave.
interface wdma0_if;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic [3:0]  AWID;
  logic        AWLOCK;
  logic [3:0]  AWCACHE;
  logic [2:0]  AWPROT;
  logic [3:0]  AWQOS;
  logic        WVALID;
  logic        WREADY;
  logic [63:0] WDATA;
  logic [7:0]  WSTRB;
  logic        WLAST;
  logic        BVALID;
  logic        BREADY;
  logic [1:0]  BRESP;

  modport master (
    output AWVALID, AWADDR, AWLEN, AWSIZE, AWBURST, AWID, AWLOCK, AWCACHE, AWPROT, AWQOS,
    input  AWREADY,
    output WVALID, WDATA, WSTRB, WLAST,
    input  WREADY,
    input  BVALID, BRESP,
    output BREADY
  );

  modport slave (
    input  AWVALID, AWADDR, AWLEN, AWSIZE, AWBURST, AWID, AWLOCK, AWCACHE, AWPROT, AWQOS,
    output AWREADY,
    input  WVALID, WDATA, WSTRB, WLAST,
    output WREADY,
    output BVALID, BRESP,
    input  BREADY
  );
endinterface

// File: rtl/wdma0.sv
// Stream-to-AXI write DMA: splits a byte range into INCR bursts (never crossing 4 KB)
// and pushes the 64-bit source stream out on W, tracking outstanding bursts and B responses.
module wdma0 #(
  parameter int MAX_BURST = 32,
  parameter int MAX_OUTST = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wdma0_start,
  input  logic [31:0] base_addr,
  input  logic [31:0] transfer_byte,
  input  logic [63:0] wdma0_data,
  input  logic        wdma0_valid,
  output logic        wdma0_ready,
  output logic        wdma0_busy,
  output logic        wdma0_done,
  output logic        wdma0_err,
  wdma0_if.master     axi_wdma0
);
  localparam int PW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int CW = $clog2(MAX_OUTST + 1);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_RUN, S_WAIT_B, S_DONE} state_t;
  state_t state, state_nx;

  logic          start_q;
  logic [31:0]   addr;
  logic [31:0]   remaining;
  logic [7:0]    fifo_mem [MAX_OUTST];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] fifo_cnt;
  logic [7:0]    beat_cnt;
  logic [15:0]   outst;
  logic          err_q;

  logic        start_edge, fifo_full, fifo_empty;
  logic [31:0] to_4k, burst;
  logic [7:0]  aw_len;
  logic        aw_valid, aw_hs, w_active, w_last, w_valid, w_hs, b_hs, push, pop;

  // byte count is a multiple of 8; the low bits carry no information
  logic unused_low;
  assign unused_low = ^transfer_byte[2:0];

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTST - 1)) ? '0 : p + PW'(1);
  endfunction

  assign start_edge = wdma0_start & ~start_q;
  assign fifo_full  = (fifo_cnt == CW'(MAX_OUTST));
  assign fifo_empty = (fifo_cnt == '0);

  // beats left before the next 4 KB page: 1..512
  assign to_4k = 32'd512 - {23'd0, addr[11:3]};

  always_comb begin
    burst = remaining;
    if (burst > 32'(MAX_BURST)) burst = 32'(MAX_BURST);
    if (burst > to_4k)          burst = to_4k;
  end
  assign aw_len = 8'(burst - 32'd1);

  assign aw_valid = (state == S_RUN) && !fifo_full;
  assign aw_hs    = aw_valid && axi_wdma0.AWREADY;
  assign push     = aw_hs;

  // W only runs against a length already accepted on AW, so the stream is
  // never drained past the programmed byte count
  assign w_active = !fifo_empty;
  assign w_last   = w_active && (beat_cnt == fifo_mem[rd_ptr]);
  assign w_valid  = wdma0_valid && w_active;
  assign w_hs     = w_valid && axi_wdma0.WREADY;
  assign pop      = w_hs && w_last;
  assign b_hs     = axi_wdma0.BVALID && wdma0_busy;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start_edge) state_nx = S_PRE;
      S_PRE:    state_nx = (remaining == '0) ? S_DONE : S_RUN;
      S_RUN:    if (aw_hs && remaining == burst) state_nx = S_WAIT_B;
      S_WAIT_B: if (remaining == '0 && fifo_empty && outst == '0) state_nx = S_DONE;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      start_q   <= 1'b0;
      addr      <= '0;
      remaining <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      beat_cnt  <= '0;
      outst     <= '0;
      err_q     <= 1'b0;
    end else begin
      state   <= state_nx;
      start_q <= wdma0_start;
      if (state == S_IDLE && start_edge) begin
        addr      <= base_addr;
        remaining <= {3'b000, transfer_byte[31:3]};
        err_q     <= 1'b0;
      end else if (b_hs && axi_wdma0.BRESP != 2'b00) begin
        err_q <= 1'b1;
      end
      if (aw_hs) begin
        addr      <= addr + (burst << 3);
        remaining <= remaining - burst;
        wr_ptr    <= nxt(wr_ptr);
      end
      if (pop) begin
        rd_ptr   <= nxt(rd_ptr);
        beat_cnt <= '0;
      end else if (w_hs) begin
        beat_cnt <= beat_cnt + 8'd1;
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
      case ({aw_hs, b_hs})
        2'b10:   outst <= outst + 16'd1;
        2'b01:   outst <= outst - 16'd1;
        default: outst <= outst;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= aw_len;
  end

  assign wdma0_busy  = (state == S_PRE) || (state == S_RUN) || (state == S_WAIT_B);
  assign wdma0_done  = (state == S_DONE);
  assign wdma0_err   = err_q;
  assign wdma0_ready = axi_wdma0.WREADY && w_active;

  assign axi_wdma0.AWVALID = aw_valid;
  assign axi_wdma0.AWADDR  = addr;
  assign axi_wdma0.AWLEN   = (state == S_RUN) ? aw_len : 8'd0;
  assign axi_wdma0.AWSIZE  = 3'b011;
  assign axi_wdma0.AWBURST = 2'b01;
  assign axi_wdma0.AWID    = '0;
  assign axi_wdma0.AWLOCK  = 1'b0;
  assign axi_wdma0.AWCACHE = '0;
  assign axi_wdma0.AWPROT  = '0;
  assign axi_wdma0.AWQOS   = '0;
  assign axi_wdma0.WVALID  = w_valid;
  assign axi_wdma0.WDATA   = wdma0_data;
  assign axi_wdma0.WSTRB   = 8'hFF;
  assign axi_wdma0.WLAST   = w_last;
  assign axi_wdma0.BREADY  = wdma0_busy;
endmodule

// File: tb/tb_wdma0.sv
// Directed bench for wdma0: AXI slave responder, stream source and logging monitor,
// with a linear sequence of transfers checked against hand-computed burst plans.
module tb_wdma0;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] base = '0;
  logic [31:0] bytes = '0;
  logic [63:0] sdata = '0;
  logic        svalid = 1'b0;
  logic        sready, busy, done, err;

  wdma0_if axi();

  always #5 clk = ~clk;

  wdma0 #(.MAX_BURST(32), .MAX_OUTST(4)) dut (
    .clk(clk), .rst_n(rst_n), .wdma0_start(start), .base_addr(base), .transfer_byte(bytes),
    .wdma0_data(sdata), .wdma0_valid(svalid), .wdma0_ready(sready), .wdma0_busy(busy),
    .wdma0_done(done), .wdma0_err(err), .axi_wdma0(axi)
  );

  // monitor state, written only by the negedge block
  int aw_n = 0, w_n = 0, wl_n = 0, b_n = 0, src_n = 0, done_n = 0;
  int stab_bad = 0, cross_bad = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr = '0;
  logic [7:0]  prev_len = '0;
  logic [31:0] aw_addr_q[$];
  logic [7:0]  aw_len_q[$];
  logic [63:0] wd_q[$];
  logic        wl_q[$];

  int err_at = -1;

  // inputs are driven at posedge+1, so a negedge sample sees exactly what the next edge will see
  always @(negedge clk) begin
    if (!rst_n) begin
      b_n = wl_n;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && !(axi.AWVALID && axi.AWADDR == prev_addr && axi.AWLEN == prev_len))
        stab_bad++;
      prev_stall = axi.AWVALID && !axi.AWREADY;
      prev_addr  = axi.AWADDR;
      prev_len   = axi.AWLEN;
      if (axi.AWVALID && axi.AWREADY) begin
        aw_addr_q.push_back(axi.AWADDR);
        aw_len_q.push_back(axi.AWLEN);
        if ({20'd0, axi.AWADDR[11:0]} + (32'(axi.AWLEN) + 32'd1) * 32'd8 > 32'd4096) cross_bad++;
        aw_n++;
      end
      if (axi.WVALID && axi.WREADY) begin
        wd_q.push_back(axi.WDATA);
        wl_q.push_back(axi.WLAST);
        w_n++;
        if (axi.WLAST) wl_n++;
      end
      if (svalid && sready) src_n++;
      if (axi.BVALID && axi.BREADY) b_n++;
      if (done) done_n++;
    end
  end

  // slave B responder and stream source
  always begin
    @(posedge clk); #1;
    axi.BVALID = (wl_n != b_n);
    axi.BRESP  = (b_n == err_at) ? 2'b10 : 2'b00;
    sdata      = {32'hDA7A_0000, 32'(src_n)};
  end

  int n_chk = 0, n_pass = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // expected burst plan for the transfer under test
  logic [31:0] ea[16];
  logic [7:0]  el[16];
  int ne;
  int s_aw, s_w, s_src, s_done, s_b;

  task automatic launch(input logic [31:0] b, input logic [31:0] nb);
    s_aw = aw_n; s_w = w_n; s_src = src_n; s_done = done_n; s_b = b_n;
    base = b; bytes = nb; start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic finish(input string tag, input logic [31:0] nb, input int budget);
    int k, beats, bad_data, bad_last, idx, next_end;
    k = 0;
    while (done_n == s_done && k < budget) begin cyc(1); k++; end
    cyc(3);
    beats = int'(nb >> 3);
    chk({tag, " done pulses"}, 64'(done_n - s_done), 64'd1);
    chk({tag, " busy after"}, 64'(busy), 64'd0);
    chk({tag, " aw count"}, 64'(aw_n - s_aw), 64'(ne));
    for (int i = 0; i < ne && s_aw + i < aw_n; i++) begin
      chk($sformatf("%s aw%0d addr", tag, i), 64'(aw_addr_q[s_aw + i]), 64'(ea[i]));
      chk($sformatf("%s aw%0d len", tag, i), 64'(aw_len_q[s_aw + i]), 64'(el[i]));
    end
    chk({tag, " w beats"}, 64'(w_n - s_w), 64'(beats));
    chk({tag, " stream beats"}, 64'(src_n - s_src), 64'(beats));
    chk({tag, " b count"}, 64'(b_n - s_b), 64'(ne));
    bad_data = 0; bad_last = 0; idx = 0;
    next_end = (ne > 0) ? int'(el[0]) + 1 : -1;
    for (int i = 0; i < beats && s_w + i < w_n; i++) begin
      if (wd_q[s_w + i] !== {32'hDA7A_0000, 32'(s_src + i)}) bad_data++;
      if (wl_q[s_w + i] !== (i + 1 == next_end)) bad_last++;
      if (i + 1 == next_end) begin
        idx++;
        if (idx < ne) next_end += int'(el[idx]) + 1;
      end
    end
    chk({tag, " data order"}, 64'(bad_data), 64'd0);
    chk({tag, " wlast pattern"}, 64'(bad_last), 64'd0);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " awvalid"}, 64'(axi.AWVALID), 64'd0);
    chk({tag, " awaddr"}, 64'(axi.AWADDR), 64'd0);
    chk({tag, " awlen"}, 64'(axi.AWLEN), 64'd0);
    chk({tag, " wvalid"}, 64'(axi.WVALID), 64'd0);
    chk({tag, " wlast"}, 64'(axi.WLAST), 64'd0);
    chk({tag, " bready"}, 64'(axi.BREADY), 64'd0);
    chk({tag, " ready"}, 64'(sready), 64'd0);
    chk({tag, " busy"}, 64'(busy), 64'd0);
    chk({tag, " done"}, 64'(done), 64'd0);
    chk({tag, " err"}, 64'(err), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    svalid = 1'b1;
    axi.AWREADY = 1'b1;
    axi.WREADY  = 1'b1;
    cyc(3);
    chk_quiet("reset");
    rst_n = 1'b1;
    cyc(2);
    chk("idle busy", 64'(busy), 64'd0);

    // single 8-beat burst
    ne = 1; ea[0] = 32'h1000_0000; el[0] = 8'd7;
    launch(32'h1000_0000, 32'd64);
    chk("t1 busy", 64'(busy), 64'd1);
    finish("t1", 32'd64, 200);
    chk("t1 err", 64'(err), 64'd0);

    // two max bursts, AW held off first
    ne = 2; ea[0] = 32'h1000_0000; el[0] = 8'd31; ea[1] = 32'h1000_0100; el[1] = 8'd31;
    axi.AWREADY = 1'b0;
    launch(32'h1000_0000, 32'd512);
    cyc(6);
    chk("t2 awvalid stalled", 64'(axi.AWVALID), 64'd1);
    chk("t2 awaddr stalled", 64'(axi.AWADDR), 64'h1000_0000);
    chk("t2 awlen stalled", 64'(axi.AWLEN), 64'd31);
    axi.AWREADY = 1'b1;
    finish("t2", 32'd512, 400);
    chk("t2 aw stable", 64'(stab_bad), 64'd0);

    // 4 KB split
    ne = 2; ea[0] = 32'h0000_0FC0; el[0] = 8'd7; ea[1] = 32'h0000_1000; el[1] = 8'd23;
    launch(32'h0000_0FC0, 32'd256);
    finish("t3", 32'd256, 300);
    chk("t3 no 4k cross", 64'(cross_bad), 64'd0);

    // W stalled: AW runs ahead only as far as the burst FIFO allows
    ne = 8;
    for (int i = 0; i < 8; i++) begin ea[i] = 32'h2000_0000 + 32'(i * 256); el[i] = 8'd31; end
    axi.WREADY = 1'b0;
    launch(32'h2000_0000, 32'd2048);
    cyc(50);
    chk("t4 aw ahead of w", 64'(aw_n - s_aw), 64'd4);
    chk("t4 no w yet", 64'(w_n - s_w), 64'd0);
    chk("t4 awvalid full", 64'(axi.AWVALID), 64'd0);
    chk("t4 awaddr held", 64'(axi.AWADDR), 64'h2000_0400);
    axi.WREADY = 1'b1;
    finish("t4", 32'd2048, 1500);
    chk("t4 aw stable", 64'(stab_bad), 64'd0);

    // error response on the second burst
    ne = 2; ea[0] = 32'h1000_0000; el[0] = 8'd31; ea[1] = 32'h1000_0100; el[1] = 8'd31;
    err_at = b_n + 1;
    launch(32'h1000_0000, 32'd512);
    finish("t5", 32'd512, 400);
    chk("t5 err set", 64'(err), 64'd1);
    err_at = -1;
    cyc(5);
    chk("t5 err sticky", 64'(err), 64'd1);

    // new start clears err; a start edge while busy is ignored
    ne = 2; ea[0] = 32'h4000_0000; el[0] = 8'd31; ea[1] = 32'h4000_0100; el[1] = 8'd31;
    launch(32'h4000_0000, 32'd512);
    chk("t6 err cleared", 64'(err), 64'd0);
    cyc(10);
    base = 32'h3000_0000; bytes = 32'd64; start = 1'b1;
    cyc(2);
    start = 1'b0;
    finish("t6", 32'd512, 400);

    // zero-length transfer
    ne = 0;
    launch(32'h5000_0000, 32'd0);
    finish("t7", 32'd0, 20);

    // reset mid-burst
    launch(32'h6000_0000, 32'd2048);
    cyc(20);
    chk("t8 busy before rst", 64'(busy), 64'd1);
    d0 = done_n;
    rst_n = 1'b0;
    cyc(1);
    chk_quiet("t8 rst");
    cyc(3);
    rst_n = 1'b1;
    cyc(3);
    chk("t8 no done", 64'(done_n - d0), 64'd0);

    // clean transfer after reset
    ne = 1; ea[0] = 32'h7000_0000; el[0] = 8'd7;
    launch(32'h7000_0000, 32'd64);
    finish("t9", 32'd64, 200);
    chk("t9 err", 64'(err), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/wdma0.md
WDMA0 -- requirements
Module: wdma0

Interface
REQ-001 SHALL have parameter MAX_BURST, default 32, maximum beats per AW burst (power of 2, <=256).
REQ-002 SHALL have parameter MAX_OUTST, default 4, maximum AW bursts issued but not yet fully sent on W (depth of internal burst-length FIFO).
REQ-003 SHALL have ports:
  clk  in  1  clock, all logic on rising edge
  rst_n  in  1  reset, synchronous, active-low
  wdma0_start  in  1  level; rising edge starts a transfer
  base_addr  in  32  destination byte address, 8-byte aligned, sampled at start
  transfer_byte  in  32  byte count, multiple of 8, sampled at start
  wdma0_data  in  64  source stream data
  wdma0_valid  in  1  source data valid
  wdma0_ready  out  1  stream accepts beat (= WREADY & W-channel active)
  wdma0_busy  out  1  high from start edge until done
  wdma0_done  out  1  one-cycle pulse when last B response received
  wdma0_err  out  1  sticky; set on any BRESP != OKAY, cleared at next start
  axi_wdma0_AWVALID/AWREADY  out/in  1  AW handshake
  axi_wdma0_AWADDR  out  32  burst address
  axi_wdma0_AWLEN  out  8  beats-1
  axi_wdma0_AWSIZE/AWBURST  out  3/2  constant 3'b011 / 2'b01 (INCR); AWID, AWLOCK, AWCACHE, AWPROT, AWQOS tied 0
  axi_wdma0_WVALID/WREADY  out/in  1  W handshake
  axi_wdma0_WDATA  out  64  = wdma0_data
  axi_wdma0_WSTRB  out  8  constant 8'hFF
  axi_wdma0_WLAST  out  1  last beat of current burst
  axi_wdma0_BVALID/BREADY/BRESP  in/out/in  1/1/2  B channel

Function
REQ-004 SHALL detect start as wdma0_start high while previous-cycle value low; start edges while busy SHALL be ignored.
REQ-005 SHALL run top FSM IDLE -> PRE (latch base_addr, finish = base_addr+transfer_byte, beats = transfer_byte>>3) -> RUN (issue AW) -> WAIT_B (all AW issued) -> DONE (one cycle, done pulse) -> IDLE.
REQ-006 transfer_byte==0 SHALL go PRE -> DONE with no AXI activity.
REQ-007 Burst length SHALL be min(remaining beats, MAX_BURST, beats to next 4 KB boundary); a burst SHALL never cross a 4 KB address boundary.
REQ-008 AWVALID SHALL be asserted only in RUN and only when burst FIFO not full; AWADDR/AWLEN SHALL stay stable while AWVALID high and not accepted.
REQ-009 On AW handshake: address += len*8, remaining -= len, len pushed into burst FIFO; when remaining reaches 0, FSM SHALL enter WAIT_B.
REQ-010 W channel SHALL be active only while burst FIFO non-empty; WVALID = wdma0_valid & active; wdma0_ready = WREADY & active; WDATA combinational pass-through.
REQ-011 W beat counter (8 bits) SHALL increment per W handshake; WLAST high when counter == head length-1; on WLAST handshake counter clears and FIFO pops.
REQ-012 W beats MAY precede their AW handshake only after the length is in the FIFO (i.e., never before AW accepted).
REQ-013 Simultaneous FIFO push and pop SHALL keep occupancy unchanged.
REQ-014 BREADY SHALL be 1 whenever busy; outstanding-B counter SHALL increment on AW handshake, decrement on B handshake, both same cycle -> unchanged.
REQ-015 WAIT_B -> DONE SHALL occur when remaining==0, FIFO empty and outstanding-B==0.
REQ-016 Data beyond transfer_byte SHALL never be consumed from the stream.

Reset
REQ-017 On rst_n low at clk edge: FSM IDLE, FIFO empty, counters 0, all VALID/READY/LAST/busy/done/err outputs 0, AWADDR 0, AWLEN 0.
REQ-018 Reset mid-transfer SHALL abandon the transfer with no done pulse; next start SHALL behave as from power-up.

Verification
REQ-019 base 0x1000_0000, 64 B, WREADY/AWREADY/BVALID responsive -> one AW addr 0x1000_0000 len 7, 8 W beats WLAST on 8th, done 1 cycle after DONE entry, err 0.
REQ-020 base 0x1000_0000, 512 B -> AW len 31 at 0x1000_0000 and 0x1000_0100, 64 beats, 2 WLASTs, done after 2nd B.
REQ-021 base 0x0000_0FC0, 256 B -> AW 0x0000_0FC0 len 7, AW 0x0000_1000 len 23; no burst crosses 0x1000.
REQ-022 AWREADY held 1, WREADY low 50 cycles, 2 KB transfer -> exactly MAX_OUTST AW accepted before first W beat; AWADDR stable while stalled; all 256 beats delivered in order.
REQ-023 BRESP=2'b10 on one burst -> err sticky 1, done still pulses; next start clears err.
REQ-024 Start edge during busy ignored; rst_n low mid-burst -> all outputs 0 next cycle, no done pulse.
